// File: rtl/fetch_stage.sv
// fetch_stage: issues instruction-memory requests, keeps an in-order fetch queue of
// in-flight and returned words, and presents the oldest returned word to decode.
// Responses still in flight when a redirect arrives are counted in drop_q and discarded.
module fetch_stage #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned              FQ_DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_d,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     instr_valid_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f
);

  localparam int unsigned PTR_W    = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(FQ_DEPTH + 1);
  localparam int unsigned DROP_W   = 8;
  localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  // Circular-buffer index advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [CNT_W-1:0] off);
    int unsigned s;
    s = 32'(base) + 32'(off);
    if (s >= FQ_DEPTH) s = s - FQ_DEPTH;
    return PTR_W'(s);
  endfunction

  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  // Filled entries always form a prefix of the queue, so a count replaces per-entry flags.
  logic [CNT_W-1:0]         filled_q, filled_d;
  logic [DROP_W-1:0]        drop_q, drop_d;

  logic [ADDRESS_WIDTH-1:0] pc_mem_q    [FQ_DEPTH];
  logic [DATA_WIDTH-1:0]    instr_mem_q [FQ_DEPTH];

  logic [CNT_W-1:0]  unfilled;
  logic              head_vld;
  logic              pop;
  logic              q_full;
  logic              issue;
  logic              rsp_drop;
  logic              fill;
  logic [PTR_W-1:0]  fill_idx;
  logic [DROP_W-1:0] redir_drop;

  assign unfilled  = count_q - filled_q;
  assign head_vld  = (filled_q != '0);
  assign pop       = head_vld & ~stall_d & ~pc_src_e;
  assign q_full    = (count_q == CNT_W'(FQ_DEPTH));
  assign imem_req  = ~rst & ~pc_src_e & (~q_full | pop);
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req & imem_ready;
  assign rsp_drop  = imem_rvalid & (drop_q != '0);
  assign fill      = imem_rvalid & (drop_q == '0) & (unfilled != '0) & ~pc_src_e;
  assign fill_idx  = wrap_add(head_q, filled_q);

  // Drop count after a redirect: everything still owed by imem, minus a response landing now.
  always_comb begin
    int unsigned sum;
    sum = 32'(drop_q) + 32'(unfilled);
    if (imem_rvalid && sum != 0) sum = sum - 1;
    if (sum > DROP_MAX) sum = DROP_MAX;
    redir_drop = DROP_W'(sum);
  end

  // Next-state for fetch PC, queue pointers/counters and drop accounting.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    filled_d   = filled_q;
    drop_d     = drop_q;
    if (pc_src_e) begin
      fetch_pc_d = {pc_target_e[ADDRESS_WIDTH-1:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      filled_d   = '0;
      drop_d     = redir_drop;
    end else begin
      if (rsp_drop) drop_d = drop_q - DROP_W'(1);
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(4);
        tail_d     = wrap_add(tail_q, CNT_W'(1));
      end
      if (pop) head_d = wrap_add(head_q, CNT_W'(1));
      count_d  = count_q + CNT_W'(issue) - CNT_W'(pop);
      filled_d = filled_q + CNT_W'(fill) - CNT_W'(pop);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      filled_q   <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      filled_q   <= filled_d;
      drop_q     <= drop_d;
    end
  end

  // Queue payload: PC captured at issue, instruction captured at fill; validity lives in the counters.
  always_ff @(posedge clk) begin
    if (issue) pc_mem_q[tail_q] <= fetch_pc_q;
    if (fill)  instr_mem_q[fill_idx] <= imem_rdata;
  end

  // Decode-facing view of the queue head; NOP bubble when the head has not returned yet.
  always_comb begin
    instr_valid_f = head_vld;
    instr_f       = NOP;
    pc_f          = '0;
    pc_plus4_f    = ADDRESS_WIDTH'(4);
    if (head_vld) begin
      instr_f    = instr_mem_q[head_q];
      pc_f       = pc_mem_q[head_q];
      pc_plus4_f = pc_mem_q[head_q] + ADDRESS_WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random stall/ready/redirect/reset stimulus against a queue-level
// model of the fetch stage plus an in-order variable-latency imem model.
module tb_fetch_stage;

  localparam int FQ = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid_f;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;

  fetch_stage #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .RESET_PC     (32'h0000_0000),
    .FQ_DEPTH     (FQ)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_d      (stall_d),
    .pc_src_e     (pc_src_e),
    .pc_target_e  (pc_target_e),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid_f(instr_valid_f),
    .instr_f      (instr_f),
    .pc_f         (pc_f),
    .pc_plus4_f   (pc_plus4_f)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit known = 1'b0;

  // Fetch-stage model: a queue of {pc, instr, filled} plus next fetch address and drop count.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fpc;
  int          m_drop;

  // imem model: in-order pending requests, each with the cycle its response becomes due.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t imq[$];

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], a[15:0]} ^ 32'h0050_0093;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_cycle(input bit r, input bit st, input bit red, input logic [31:0] tgt,
                          input bit rdy, input int lat);
    bit          rv;
    logic [31:0] rd;
    bit          hv, pop, req, iss;
    logic [31:0] e_instr, e_pc, e_pc4;
    int          unf, tot;
    @(negedge clk);
    rst         = r;
    stall_d     = st;
    pc_src_e    = red;
    pc_target_e = tgt;
    imem_ready  = rdy;
    rv = !r && (imq.size() > 0) && (imq[0].due <= cyc);
    rd = rv ? imem_word(imq[0].addr) : $urandom;
    imem_rvalid = rv;
    imem_rdata  = rd;
    #1;
    hv  = (mq.size() > 0) && mq[0].filled;
    pop = hv && !st && !red;
    req = !r && !red && ((mq.size() < FQ) || pop);
    iss = req && rdy;
    e_instr = hv ? mq[0].instr : NOP;
    e_pc    = hv ? mq[0].pc : 32'h0;
    e_pc4   = e_pc + 32'd4;
    if (known) begin
      chk_eq("imem_req", 32'(imem_req), 32'(req));
      chk_eq("imem_addr", imem_addr, m_fpc);
      chk_eq("instr_valid_f", 32'(instr_valid_f), 32'(hv));
      chk_eq("instr_f", instr_f, e_instr);
      chk_eq("pc_f", pc_f, e_pc);
      chk_eq("pc_plus4_f", pc_plus4_f, e_pc4);
    end
    if (rv) void'(imq.pop_front());
    if (iss) imq.push_back('{addr: m_fpc, due: cyc + lat});
    if (r) begin
      mq.delete();
      imq.delete();
      m_fpc  = 32'h0;
      m_drop = 0;
      known  = 1'b1;
    end else if (red) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      tot = m_drop + unf - (rv ? 1 : 0);
      m_drop = (tot < 0) ? 0 : tot;
      mq.delete();
      m_fpc = {tgt[31:2], 2'b00};
    end else begin
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].instr  = rd;
              mq[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (iss) begin
        mq.push_back('{pc: m_fpc, instr: 32'h0, filled: 1'b0});
        m_fpc = m_fpc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run_phase(input int n, input int p_stall, input int p_red, input int p_nrdy,
                           input int lat_lo, input int lat_hi);
    bit          st, red, rdy;
    logic [31:0] tgt;
    for (int k = 0; k < n; k++) begin
      st  = ($urandom_range(0, 99) < p_stall);
      red = ($urandom_range(0, 99) < p_red);
      rdy = ($urandom_range(0, 99) >= p_nrdy);
      tgt = ($urandom_range(0, 3) == 0) ? 32'h0000_0103 : $urandom;
      do_cycle(1'b0, st, red, tgt, rdy, $urandom_range(lat_lo, lat_hi));
    end
  endtask

  initial begin
    rst         = 1'b1;
    stall_d     = 1'b0;
    pc_src_e    = 1'b0;
    pc_target_e = '0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    m_fpc       = 32'h0;
    m_drop      = 0;

    repeat (3) do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    // Streaming at 1-cycle latency, no stalls.
    run_phase(40, 0, 0, 0, 1, 1);
    // Decode stalls and imem back-pressure.
    run_phase(400, 35, 0, 30, 1, 3);
    // Redirects over a slower imem so responses are in flight when they land.
    run_phase(600, 25, 10, 20, 1, 4);
    // Reset in the middle of traffic.
    repeat (2) do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    run_phase(30, 0, 0, 0, 1, 1);
    // Dense redirects, including back-to-back ones.
    run_phase(400, 30, 35, 25, 1, 3);
    run_phase(100, 10, 5, 10, 3, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
